alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Command-side master for the 16-bit combinational ALU. It accepts operation commands over a valid/ready interface and drives the ALU's operand and opcode inputs from registers.
- It samples the ALU result, keeps a running accumulator, and returns tagged responses over a second valid/ready interface.
- It sits between the instruction front end and the ALU, and it is the only block allowed to drive the ALU inputs.

Parameters:
- WIDTH, 16, datapath width; must match the ALU operand/result width.
- TAG_W, 4, width of the command tag echoed in the response.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT; 110/111 illegal.
- cmd_a  input  WIDTH  operand A, used when cmd_use_acc=0.
- cmd_b  input  WIDTH  operand B.
- cmd_use_acc  input  1  1 = use the accumulator as operand A instead of cmd_a.
- cmd_tag  input  TAG_W  opaque tag, returned with the response.
- acc_clr  input  1  synchronous accumulator clear.
- alu_a  output  WIDTH  registered operand A to the ALU.
- alu_b  output  WIDTH  registered operand B to the ALU.
- alu_op  output  3  registered opcode to the ALU.
- alu_result  input  WIDTH  combinational ALU result.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  downstream accepts the response.
- rsp_data  output  WIDTH  captured result; 0 on error.
- rsp_tag  output  TAG_W  tag of the command being answered.
- rsp_err  output  1  1 = illegal opcode, no ALU operation performed.
- acc  output  WIDTH  current accumulator value.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - State goes to IDLE.
  - cmd_ready=0 while rst_n low, 1 in the first cycle after release.
  - rsp_valid=0, rsp_err=0.
  - rsp_data, rsp_tag, alu_a, alu_b, alu_op and acc all reset to 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1, rsp_valid=0.
  - A command is accepted on any edge with cmd_valid=1.
  - Legal op:
    - Load alu_op=cmd_op and alu_b=cmd_b.
    - Load alu_a = acc when cmd_use_acc=1, otherwise cmd_a.
    - Latch the tag and go to ISSUE.
  - Illegal op (110/111):
    - alu_a/alu_b/alu_op keep their previous values.
    - Latch the tag, set rsp_err=1, rsp_data=0, acc unchanged, go directly to RESP.
- ISSUE:
  - Lasts one cycle; cmd_ready=0.
  - The ALU settles combinationally from the registered inputs.
  - At the exiting edge: rsp_data<=alu_result, acc<=alu_result, rsp_err<=0, go to RESP.
- RESP:
  - rsp_valid=1 and cmd_ready=0.
  - rsp_data, rsp_tag and rsp_err are held stable until the edge where rsp_ready=1; then go to IDLE.
  - rsp_valid must never drop without a handshake, except on reset.
- Latency:
  - Command accepted at edge N gives rsp_valid high after edge N+1 (legal op) or after edge N (illegal op).
  - Peak throughput is one legal command per 3 cycles when rsp_ready is tied high.
- Accumulator:
  - acc_clr is honoured only in IDLE.
  - If acc_clr and a use_acc command are accepted on the same edge, the clear wins first: operand A = 0, and acc = 0 until ISSUE writes the result.
  - acc_clr in ISSUE/RESP is ignored.
- Arithmetic:
  - Results are modulo 2^WIDTH; no carry, borrow or overflow flag.
  - SUB is alu_a - alu_b in two's complement wrap.
  - NOT ignores alu_b, which is still driven from cmd_b.
- alu_* outputs hold their last legal values while idle, so the ALU never sees an illegal opcode from this block.
- Reset mid-operation: any in-flight command and pending response are discarded, with no response emitted.

Test Plan:
- Reset, then ADD a=16'h1234, b=16'h0F0F, tag=3 -> alu_op=000 after accept edge; rsp_valid two edges later with rsp_data=16'h2143, rsp_tag=3, rsp_err=0; acc=16'h2143.
- SUB a=16'h0000, b=16'h0001, then NOT with use_acc=1 -> first rsp_data=16'hFFFF (wrap); second rsp_data=16'h0000; acc=16'h0000.
- Illegal op 3'b110, tag=9, acc preloaded 16'h00AA -> rsp_valid after one edge, rsp_err=1, rsp_data=0, acc stays 16'h00AA, alu_op unchanged.
- Hold rsp_ready=0 for 5 cycles with cmd_valid held high -> rsp_valid/data/tag stable, cmd_ready=0 throughout; the next command is accepted only after the handshake edge.
- acc=16'h5555, acc_clr=1 together with OR use_acc=1, b=16'h0F00 -> alu_a=0, rsp_data=16'h0F00, acc=16'h0F00.
- Assert rst_n low during ISSUE and during RESP -> rsp_valid and acc go to 0 immediately with no clock edge; after release cmd_ready=1 and no response appears.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Command-side master for the combinational ALU: registers operands and opcode,
// captures the result into an accumulator and returns tagged responses.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_*             command valid/ready channel (op, a, b, use_acc, tag)
//   acc_clr           synchronous accumulator clear, honoured only in IDLE
//   alu_a/b/op        registered ALU inputs (hold last legal values)
//   alu_result        combinational ALU result
//   rsp_*             response valid/ready channel (data, tag, err)
//   acc               current accumulator value
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic [TAG_W-1:0] cmd_tag,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    localparam logic [2:0] OP_LAST = 3'b101;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             issue_done;
    logic             legal;
    logic             clr_en;
    logic [WIDTH-1:0] op_a;

    assign legal = (cmd_op <= OP_LAST);

    // A clear accepted with a use_acc command wins: operand A sees zero.
    assign op_a = cmd_use_acc ? (acc_clr ? '0 : acc) : cmd_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        issue_done = 1'b0;
        clr_en     = 1'b0;
        unique case (state)
            IDLE: begin
                // Held low through reset; state is already IDLE then.
                cmd_ready = rst_n;
                clr_en    = acc_clr;
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                issue_done = 1'b1;
                state_nx   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand registers only change on legal accepts, so the ALU never
    // sees an illegal opcode from this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (accept && legal) begin
            alu_a  <= op_a;
            alu_b  <= cmd_b;
            alu_op <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_tag <= '0;
        end else if (accept) begin
            rsp_tag <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (issue_done) begin
            rsp_data <= alu_result;
            rsp_err  <= 1'b0;
        end else if (accept && !legal) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (issue_done) begin
            acc <= alu_result;
        end else if (clr_en) begin
            acc <= '0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed plan steps followed by
// randomized commands checked against a transaction-level model.
module tb_alu_issue_ctrl;

    localparam int W = 16;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_use_acc;
    logic [T-1:0] cmd_tag;
    logic         acc_clr;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [T-1:0] rsp_tag;
    logic         rsp_err;
    logic [W-1:0] acc;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] acc_m;
    logic [W-1:0] pa_m;
    logic [W-1:0] pb_m;
    logic [2:0]   pop_m;

    alu_issue_ctrl #(.WIDTH(W), .TAG_W(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc), .cmd_tag(cmd_tag),
        .acc_clr(acc_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .acc(acc)
    );

    always #5 clk = ~clk;

    // The combinational ALU the controller drives.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            default: alu_result = '0;
        endcase
    end

    function automatic logic [W-1:0] ref_op(input int op, input int a,
                                            input int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            default: r = ~a;
        endcase
        return r[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_use_acc = 1'b0;
        cmd_tag     = '0;
        acc_clr     = 1'b0;
    endtask

    // One full command: accept, optional stall of the response, handshake.
    // hold_next keeps another command offered during the stall to show it
    // is not taken until the controller is back in IDLE.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic use_acc,
                          input logic [T-1:0] tag, input logic clr,
                          input int stall, input logic hold_next);
        logic [W-1:0] ea;
        logic [W-1:0] res;
        logic         legal;
        legal = (op < 3'd6);
        chk("ready_before", cmd_ready, 1'b1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        cmd_tag     = tag;
        acc_clr     = clr;
        if (clr) acc_m = '0;
        ea  = use_acc ? acc_m : a;
        res = ref_op(int'(op), int'(ea), int'(b));
        step();
        idle_inputs();
        chk("acc_after_accept", acc, acc_m);
        if (legal) begin
            pa_m  = ea;
            pb_m  = b;
            pop_m = op;
        end
        chk("alu_a", alu_a, pa_m);
        chk("alu_b", alu_b, pb_m);
        chk("alu_op", alu_op, pop_m);
        if (legal) begin
            chk("issue_valid", rsp_valid, 1'b0);
            chk("issue_ready", cmd_ready, 1'b0);
            step();
            acc_m = res;
        end
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_data", rsp_data, legal ? res : '0);
        chk("rsp_tag", rsp_tag, tag);
        chk("rsp_err", rsp_err, !legal);
        chk("acc", acc, acc_m);
        for (int i = 0; i < stall; i++) begin
            if (hold_next) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'd0;
                cmd_a     = ~pa_m;
                cmd_b     = ~pb_m;
                cmd_tag   = ~tag;
            end
            step();
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_ready", cmd_ready, 1'b0);
            chk("stall_data", rsp_data, legal ? res : '0);
            chk("stall_tag", rsp_tag, tag);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_valid", rsp_valid, 1'b0);
        chk("hs_ready", cmd_ready, 1'b1);
        chk("hs_alu_a", alu_a, pa_m);
        idle_inputs();
    endtask

    task automatic reset_model();
        acc_m = '0;
        pa_m  = '0;
        pb_m  = '0;
        pop_m = '0;
    endtask

    // Accept a legal command, advance `edges` edges, then pull reset
    // mid-cycle and verify the pending work vanishes.
    task automatic reset_during(input int edges);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_a     = 16'h1111;
        cmd_b     = 16'h2222;
        cmd_tag   = 4'd5;
        step();
        idle_inputs();
        for (int i = 1; i < edges; i++) step();
        chk("pre_rst_valid", rsp_valid, edges > 1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_acc", acc, '0);
        chk("rst_ready", cmd_ready, 1'b0);
        reset_model();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_ready", cmd_ready, 1'b1);
            chk("post_rst_valid", rsp_valid, 1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        idle_inputs();
        reset_model();
        #12;
        chk("reset_ready", cmd_ready, 1'b0);
        chk("reset_valid", rsp_valid, 1'b0);
        chk("reset_err", rsp_err, 1'b0);
        chk("reset_acc", acc, '0);
        chk("reset_alu_op", alu_op, '0);
        chk("reset_data", rsp_data, '0);
        rst_n = 1'b1;
        step();
        chk("first_ready", cmd_ready, 1'b1);

        do_cmd(3'd0, 16'h1234, 16'h0F0F, 1'b0, 4'd3, 1'b0, 0, 1'b0);
        chk("plan_add", acc, 16'h2143);

        do_cmd(3'd1, 16'h0000, 16'h0001, 1'b0, 4'd1, 1'b0, 0, 1'b0);
        chk("plan_sub_wrap", rsp_data, 16'hFFFF);
        do_cmd(3'd5, 16'h0000, 16'h1234, 1'b1, 4'd2, 1'b0, 0, 1'b0);
        chk("plan_not_acc", acc, 16'h0000);

        do_cmd(3'd0, 16'h00AA, 16'h0000, 1'b0, 4'd4, 1'b0, 0, 1'b0);
        do_cmd(3'd6, 16'hBEEF, 16'hCAFE, 1'b0, 4'd9, 1'b0, 1, 1'b0);
        chk("plan_illegal_acc", acc, 16'h00AA);
        do_cmd(3'd7, 16'h1, 16'h2, 1'b1, 4'd8, 1'b0, 0, 1'b0);

        do_cmd(3'd2, 16'hF0F0, 16'hFF00, 1'b0, 4'd6, 1'b0, 5, 1'b1);

        do_cmd(3'd4, 16'h5555, 16'h0000, 1'b0, 4'd7, 1'b0, 0, 1'b0);
        chk("plan_preload", acc, 16'h5555);
        do_cmd(3'd3, 16'hAAAA, 16'h0F00, 1'b1, 4'd10, 1'b1, 0, 1'b0);
        chk("plan_clr_or", acc, 16'h0F00);

        reset_during(1);
        reset_during(2);

        for (int n = 0; n < 60; n++) begin
            do_cmd(3'($urandom_range(0, 7)), 16'($urandom),
                   16'($urandom), 1'($urandom), 4'($urandom),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                   1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
